// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - scan sequencer driving the 3x8 decoder select inputs
//
// Steps a 3-bit code through all eight values, holding each for DIV cycles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, mode, dir      begin scan; mode 0=continuous 1=single; dir 0=up 1=down
//   hold, stop            freeze dwell/code; abort to IDLE
//   a, b, c               code bits 2..0 to the decoder
//   valid, busy           active scan value; RUN state
//   step, done            new-code pulse; single-sweep completion pulse
module decoder_scan_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic mode,
    input  logic dir,
    input  logic hold,
    input  logic stop,
    output logic a,
    output logic b,
    output logic c,
    output logic valid,
    output logic busy,
    output logic step,
    output logic done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

    logic [0:0]  state_q, state_d;
    logic [2:0]  code_q,  code_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        mode_q,  mode_d;
    logic        dir_q,   dir_d;
    logic        valid_q, valid_d;
    logic        busy_q,  busy_d;
    logic        step_q,  step_d;
    logic        done_q,  done_d;

    logic        tick;
    logic        terminal;

    assign tick     = (cnt_q == CNT_LAST) && !hold;
    // Last code of a sweep depends on the direction latched at start.
    assign terminal = dir_q ? (code_q == 3'b000) : (code_q == 3'b111);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        step_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                code_d  = 3'b000;
                cnt_d   = 16'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start && !stop) begin
                    mode_d  = mode;
                    dir_d   = dir;
                    code_d  = dir ? 3'b111 : 3'b000;
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    step_d  = 1'b1;
                end
            end
            default: begin
                if (stop) begin
                    // Abort outranks both a coincident tick and hold.
                    state_d = ST_IDLE;
                    code_d  = 3'b000;
                    cnt_d   = 16'd0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    cnt_d = 16'd0;
                    if (mode_q && terminal) begin
                        state_d = ST_IDLE;
                        code_d  = 3'b000;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Plain 3-bit arithmetic gives the continuous-mode wrap.
                        code_d = dir_q ? (code_q - 3'd1) : (code_q + 3'd1);
                        step_d = 1'b1;
                    end
                end else if (!hold) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= 3'b000;
            cnt_q   <= 16'd0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign a     = code_q[2];
    assign b     = code_q[1];
    assign c     = code_q[0];
    assign valid = valid_q;
    assign busy  = busy_q;
    assign step  = step_q;
    assign done  = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - directed vector bench for decoder_scan_ctrl
module tb_decoder_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, mode, dir, hold, stop;

    logic a4, b4, c4, v4, y4, s4, d4;
    logic a2, b2, c2, v2, y2, s2, d2;
    logic a1, b1, c1, v1, y1, s1, d1;

    decoder_scan_ctrl #(.DIV(4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dir(dir),
        .hold(hold), .stop(stop), .a(a4), .b(b4), .c(c4),
        .valid(v4), .busy(y4), .step(s4), .done(d4)
    );
    decoder_scan_ctrl #(.DIV(2)) u_div2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dir(dir),
        .hold(hold), .stop(stop), .a(a2), .b(b2), .c(c2),
        .valid(v2), .busy(y2), .step(s2), .done(d2)
    );
    decoder_scan_ctrl #(.DIV(1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dir(dir),
        .hold(hold), .stop(stop), .a(a1), .b(b1), .c(c1),
        .valid(v1), .busy(y1), .step(s1), .done(d1)
    );

    // Packed as {code[2:0], valid, busy, step, done}.
    wire [6:0] o4 = {a4, b4, c4, v4, y4, s4, d4};
    wire [6:0] o2 = {a2, b2, c2, v2, y2, s2, d2};
    wire [6:0] o1 = {a1, b1, c1, v1, y1, s1, d1};

    typedef struct {
        logic       rst_n, start, mode, dir, hold, stop;
        logic [2:0] code;
        logic       valid, busy, step, done;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add_row(input logic r, st, m, d, h, p,
                           input logic [2:0] cd, input logic v, y, s, dn);
        vec_t e;
        e.rst_n = r; e.start = st; e.mode = m; e.dir = d; e.hold = h; e.stop = p;
        e.code = cd; e.valid = v; e.busy = y; e.step = s; e.done = dn;
        tbl.push_back(e);
    endtask

    // Apply inputs for one rising edge, then sample 1 time unit after it.
    task automatic drive(input logic r, st, m, d, h, p);
        rst_n = r; start = st; mode = m; dir = d; hold = h; stop = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got code/v/busy/step/done=%b want %b", nm, act, exp);
        end
    endtask

    initial begin
        int held;
        int tp;
        logic h_in;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; dir = 1'b0; hold = 1'b0; stop = 1'b0;
        @(posedge clk);
        #1;

        // Reset held 3 cycles with start asserted.
        for (int i = 0; i < 3; i++)
            add_row(0, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        // Start continuous up; first code one cycle later.
        add_row(1, 1, 0, 0, 0, 0, 3'd0, 1, 1, 1, 0);
        // t counts edges after start. Hold for three cycles while 010 shows;
        // start pulses and mode/dir changes mid-run must be ignored.
        held = 0;
        for (int t = 1; t <= 40; t++) begin
            h_in = (t >= 9 && t <= 11);
            if (h_in) held++;
            tp = t - held;
            add_row(1, (t == 20 || t == 30), (t >= 21 && t <= 25), (t >= 21 && t <= 25),
                    h_in, 0, 3'((tp / 4) % 8), 1, 1, (tp % 4 == 0) && !h_in, 0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].start, tbl[i].mode, tbl[i].dir, tbl[i].hold, tbl[i].stop);
            chk($sformatf("vec%0d", i), o4,
                {tbl[i].code, tbl[i].valid, tbl[i].busy, tbl[i].step, tbl[i].done});
        end

        // Reset mid-scan: outputs to reset values, no done.
        drive(0, 0, 0, 0, 0, 0);
        chk("reset_midscan", o4, 7'b000_0000);

        // Stop on the tick cycle of code 101.
        drive(1, 1, 0, 0, 0, 0);
        chk("stopseq_start", o4, 7'b000_1110);
        for (int t = 1; t <= 23; t++) drive(1, 0, 0, 0, 0, 0);
        chk("stopseq_at101", o4, 7'b101_1100);
        drive(1, 0, 0, 0, 0, 1);
        chk("stop_on_tick", o4, 7'b000_0000);
        drive(1, 0, 0, 0, 0, 0);
        chk("stop_idle", o4, 7'b000_0000);
        drive(1, 1, 0, 0, 0, 1);
        chk("start_stop_idle", o4, 7'b000_0000);
        drive(1, 0, 0, 0, 1, 0);
        chk("hold_in_idle", o4, 7'b000_0000);

        // Single sweep down at DIV=2, then restart in the done cycle.
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 0);
        chk("sw2_t0", o2, 7'b111_1110);
        for (int t = 1; t <= 15; t++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk($sformatf("sw2_t%0d", t), o2, {3'(7 - t / 2), 1'b1, 1'b1, (t % 2 == 0), 1'b0});
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("sw2_done", o2, 7'b000_0001);
        drive(1, 1, 0, 0, 0, 0);
        chk("sw2_restart", o2, 7'b000_1110);
        drive(1, 0, 0, 0, 0, 0);
        chk("sw2_restart_t1", o2, 7'b000_1100);

        // DIV=1: code changes every cycle, single sweep up.
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        chk("div1_t0", o1, 7'b000_1110);
        for (int t = 1; t <= 7; t++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk($sformatf("div1_t%0d", t), o1, {3'(t), 4'b1110});
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("div1_done", o1, 7'b000_0001);
        drive(1, 0, 0, 0, 0, 0);
        chk("div1_after_done", o1, 7'b000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
